// File: rtl/seq_scan_ctrl.sv
// Programmable serial pattern scanner: accepts a frame of serial bits over a
// valid/ready handshake, pulses hit on each pattern occurrence and counts matches.
module seq_scan_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [3:0]         cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               start,
    input  logic [CNT_W-1:0]   frame_len,
    input  logic               x_valid,
    input  logic               x,
    output logic               x_ready,
    output logic               busy,
    output logic               hit,
    output logic [CNT_W-1:0]   match_count,
    output logic               done,
    output logic [1:0]         dbg_state
);
    // Handshake: a bit transfers on every rising edge where x_valid and x_ready
    // are both high; x_ready is high for the whole SCAN state and nowhere else.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);

    state_t             state_q;
    logic [MAX_LEN-1:0] pat_q;
    logic [3:0]         len_q;
    logic               ov_q;
    logic [MAX_LEN-2:0] hist_q;
    logic [3:0]         fill_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]   frame_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               hit_q;
    logic               cfg_err_q;
    logic               busy_q;
    logic               x_ready_q;
    logic               done_q;

    logic [MAX_LEN-1:0] hist_d;
    logic [3:0]         fill_d;
    logic [MAX_LEN-1:0] len_mask;
    logic               is_match;
    logic               last_bit;
    logic               cfg_ok;

    // Match is judged on the history as it will look after the incoming bit.
    always_comb begin
        hist_d   = {hist_q, x};
        fill_d   = (fill_q == MAX_LEN_L) ? fill_q : fill_q + 4'd1;
        len_mask = ~({MAX_LEN{1'b1}} << len_q);
        is_match = (fill_d >= len_q) && ((hist_d & len_mask) == (pat_q & len_mask));
        last_bit = (bit_cnt_q == frame_q - CNT_W'(1));
        cfg_ok   = (cfg_len != 4'd0) && (cfg_len <= MAX_LEN_L);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pat_q     <= MAX_LEN'(8'b0010_1101);
            len_q     <= 4'd6;
            ov_q      <= 1'b1;
            hist_q    <= '0;
            fill_q    <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            cnt_q     <= '0;
            hit_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            busy_q    <= 1'b0;
            x_ready_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            hit_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cfg_we) begin
                        if (cfg_ok) begin
                            pat_q <= cfg_pattern;
                            len_q <= cfg_len;
                            ov_q  <= cfg_overlap;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                    if (start) begin
                        cnt_q     <= '0;
                        hist_q    <= '0;
                        fill_q    <= '0;
                        bit_cnt_q <= '0;
                        frame_q   <= frame_len;
                        busy_q    <= 1'b1;
                        if (frame_len == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_SCAN;
                            x_ready_q <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (x_valid) begin
                        hist_q    <= hist_d[MAX_LEN-2:0];
                        fill_q    <= (is_match && !ov_q) ? 4'd0 : fill_d;
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (is_match) begin
                            hit_q <= 1'b1;
                            if (!(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (last_bit) begin
                            state_q   <= S_DONE;
                            x_ready_q <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    x_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_err     = cfg_err_q;
    assign x_ready     = x_ready_q;
    assign busy        = busy_q;
    assign hit         = hit_q;
    assign match_count = cnt_q;
    assign done        = done_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Bench for seq_scan_ctrl: a stream-level reference model predicts every output
// each cycle; directed frames pin hit positions and counts with literal values.
module tb_seq_scan_ctrl;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;

  logic               clk;
  logic               rst;
  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [3:0]         cfg_len;
  logic               cfg_overlap;
  logic               cfg_err;
  logic               start;
  logic [CNT_W-1:0]   frame_len;
  logic               x_valid;
  logic               x;
  logic               x_ready;
  logic               busy;
  logic               hit;
  logic [CNT_W-1:0]   match_count;
  logic               done;
  logic [1:0]         dbg_state;

  seq_scan_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_err(cfg_err),
    .start(start), .frame_len(frame_len), .x_valid(x_valid), .x(x),
    .x_ready(x_ready), .busy(busy), .hit(hit), .match_count(match_count),
    .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  localparam int P_IDLE = 0, P_SCAN = 1, P_DONE = 2;
  int               m_phase = P_IDLE;
  logic [7:0]       m_pat = 8'b0010_1101;
  int               m_len = 6;
  bit               m_ov = 1'b1;
  int               m_flen, m_n, m_since;
  int               m_cnt = 0;
  bit               m_hit = 1'b0, m_cfgerr = 1'b0;
  bit               chk_en = 1'b0;
  bit               m_stream[$];
  logic [CNT_W-1:0] exp_q[$];
  int               hits[$];

  function automatic bit tail_match();
    for (int k = 0; k < m_len; k++)
      if (m_stream[m_stream.size() - 1 - k] != m_pat[k]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = P_IDLE; m_pat = 8'b0010_1101; m_len = 6; m_ov = 1'b1;
      m_cnt = 0; m_hit = 1'b0; m_cfgerr = 1'b0; chk_en = 1'b1;
      exp_q.delete();
    end else begin
      m_hit = 1'b0; m_cfgerr = 1'b0;
      if (m_phase == P_DONE) begin
        m_phase = P_IDLE;
      end else if (m_phase == P_IDLE) begin
        if (cfg_we) begin
          if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
            m_pat = cfg_pattern; m_len = cfg_len; m_ov = cfg_overlap;
          end else m_cfgerr = 1'b1;
        end
        if (start) begin
          m_cnt = 0;
          if (frame_len == 0) begin
            m_phase = P_DONE;
            exp_q.push_back('0);
          end else begin
            m_phase = P_SCAN; m_flen = frame_len; m_n = 0; m_since = 0;
            m_stream.delete();
          end
        end
      end else begin
        if (x_valid) begin
          m_stream.push_back(x);
          m_n++; m_since++;
          if (m_since >= m_len && tail_match()) begin
            m_hit = 1'b1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (!m_ov) m_since = 0;
          end
          if (m_n == m_flen) begin
            m_phase = P_DONE;
            exp_q.push_back(CNT_W'(m_cnt));
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare (scoreboard) ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_phase != P_IDLE));
      check("x_ready", 32'(x_ready), 32'(m_phase == P_SCAN));
      check("done", 32'(done), 32'(m_phase == P_DONE));
      check("hit", 32'(hit), 32'(m_hit));
      check("cfg_err", 32'(cfg_err), 32'(m_cfgerr));
      check("match_count", 32'(match_count), 32'(m_cnt));
      if (done === 1'b1) begin
        if (exp_q.size() == 0) check("done_expected", 32'(done), 32'd0);
        else check("done_count", 32'(match_count), 32'(exp_q.pop_front()));
      end
      if (hit === 1'b1) hits.push_back(m_n);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [3:0] len, input bit ov);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_frame(input logic [255:0] fb, input int n, input bit stall, input bit inj);
    int  i, budget;
    bit  v, rdy;
    hits.delete();
    start = 1'b1; frame_len = CNT_W'(n);
    tick();
    start = 1'b0;
    if (inj) begin
      start = 1'b1; frame_len = 8'd3;
      cfg_we = 1'b1; cfg_len = 4'd0; cfg_pattern = 8'($urandom); cfg_overlap = 1'b0;
    end
    i = 0; budget = 0;
    while (i < n && budget < 5000) begin
      v = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      x_valid = v; x = fb[n - 1 - i];
      rdy = x_ready;
      tick();
      if (v && rdy) i++;
      budget++;
    end
    x_valid = 1'b0; start = 1'b0; cfg_we = 1'b0;
    if (i < n) check("bit_timeout", 32'(i), 32'(n));
    budget = 0;
    while (done !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic finish_frame();
    tick();
  endtask

  task automatic check_hits(input int n, input int p0, input int p1);
    check("hit_num", 32'(hits.size()), 32'(n));
    if (n >= 1) check("hit_pos0", 32'(hits.size() > 0 ? hits[0] : -1), 32'(p0));
    if (n >= 2) check("hit_pos1", 32'(hits.size() > 1 ? hits[1] : -1), 32'(p1));
  endtask

  task automatic zero_frame();
    hits.delete();
    start = 1'b1; frame_len = '0;
    tick();
    start = 1'b0;
    check("zero_done", 32'(done), 32'd1);
    check("zero_count", 32'(match_count), 32'd0);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [255:0] fb;
    int n;
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    start = 1'b0; frame_len = '0; x_valid = 1'b0; x = 1'b0;
    do_reset(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_x_ready", 32'(x_ready), 32'd0);
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_count", 32'(match_count), 32'd0);

    run_frame(256'(6'b101101), 6, 1'b0, 1'b0);
    check("d1_count", 32'(match_count), 32'd1);
    check_hits(1, 6, 0);
    finish_frame();

    run_frame(256'(9'b101101101), 9, 1'b0, 1'b0);
    check("ov1_count", 32'(match_count), 32'd2);
    check_hits(2, 6, 9);
    finish_frame();

    do_cfg(8'b0010_1101, 4'd6, 1'b0);
    run_frame(256'(9'b101101101), 9, 1'b0, 1'b0);
    check("ov0_count", 32'(match_count), 32'd1);
    check_hits(1, 6, 0);
    finish_frame();

    do_cfg(8'b0000_0101, 4'd3, 1'b1);
    run_frame(256'(5'b10101), 5, 1'b0, 1'b0);
    check("p3_ov1_count", 32'(match_count), 32'd2);
    check_hits(2, 3, 5);
    finish_frame();

    do_cfg(8'b0000_0101, 4'd3, 1'b0);
    run_frame(256'(5'b10101), 5, 1'b0, 1'b0);
    check("p3_ov0_count", 32'(match_count), 32'd1);
    finish_frame();

    do_cfg(8'hFF, 4'd0, 1'b1);
    check("cfg_err_len0", 32'(cfg_err), 32'd1);
    do_cfg(8'hFF, 4'd9, 1'b1);
    check("cfg_err_len9", 32'(cfg_err), 32'd1);
    run_frame(256'(5'b10101), 5, 1'b0, 1'b0);
    check("cfg_kept_count", 32'(match_count), 32'd1);
    finish_frame();

    do_cfg(8'b0010_1101, 4'd6, 1'b1);
    run_frame(256'(9'b101101101), 9, 1'b0, 1'b1);
    check("inj_count", 32'(match_count), 32'd2);
    check_hits(2, 6, 9);
    finish_frame();

    run_frame(256'(9'b101101101), 9, 1'b1, 1'b0);
    check("stall_count", 32'(match_count), 32'd2);
    check_hits(2, 6, 9);
    finish_frame();

    zero_frame();

    // abort a scan after its fourth bit
    start = 1'b1; frame_len = 8'd9;
    tick();
    start = 1'b0;
    fb = 256'(9'b101101101);
    for (int k = 0; k < 4; k++) begin
      x_valid = 1'b1; x = fb[8 - k];
      tick();
    end
    x_valid = 1'b0;
    do_reset(1);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", 32'(match_count), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    tick();

    do_cfg(8'h01, 4'd1, 1'b1);
    run_frame('1, 255, 1'b0, 1'b0);
    check("max_count", 32'(match_count), 32'd255);
    finish_frame();

    for (int r = 0; r < 30; r++) begin
      do_cfg(8'($urandom),
             ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(1, 4)),
             1'($urandom_range(0, 1)));
      n = $urandom_range(0, 40);
      if (n == 0) zero_frame();
      else begin
        for (int k = 0; k < n; k++) fb[k] = 1'($urandom_range(0, 1));
        run_frame(fb, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        finish_frame();
      end
    end

    tick();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    miscompares++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
